// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and FSM state type for the
// multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_ADC = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;
    localparam logic [2:0] ALU_SBC = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Shared WIDTH+1-bit adder for ADD/SUB/ADC/SBC; subtraction adds ~B plus
// the supplied carry, so C=1 means "no borrow".
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = sub ? ~B : B;
    assign full  = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign sum   = full[WIDTH-1:0];
    assign cout  = full[WIDTH];
    // Signed overflow: operands agree in sign but the result does not.
    assign ovf   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides: single-cycle logic/arith
// ops plus an iterative shift-add multiplier; result and flags are registered.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,   // must be >= 4
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    input  logic             CarryIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlag
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] as_sum;
    logic             as_cout, as_ovf, as_cin, as_sub;
    logic [WIDTH-1:0] res_c, acc_sum;
    logic [3:0]       flags_c, mul_flags;
    logic             c_c, v_c;
    logic             accept, is_mul;

    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign is_mul   = MUL_EN && (ALUControl == ALU_MUL);

    assign as_sub = (ALUControl == ALU_SUB) || (ALUControl == ALU_SBC);
    assign as_cin = (ALUControl == ALU_ADD) ? 1'b0 :
                    (ALUControl == ALU_SUB) ? 1'b1 : CarryIn;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .A    (SrcA),
        .B    (SrcB),
        .cin  (as_cin),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

    assign acc_sum = acc + (b_sh[0] ? a_sh : '0);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (ALUControl)
            ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBC: begin
                res_c = as_sum;
                c_c   = as_cout;
                v_c   = as_ovf;
            end
            ALU_AND: res_c = SrcA & SrcB;
            ALU_ORR: res_c = SrcA | SrcB;
            ALU_EOR: res_c = SrcA ^ SrcB;
            default: res_c = '0;   // MUL reaches here only when it is illegal
        endcase

        flags_c         = '0;
        flags_c[FLAG_N] = res_c[WIDTH-1];
        flags_c[FLAG_Z] = (res_c == '0);
        flags_c[FLAG_C] = c_c;
        flags_c[FLAG_V] = v_c;

        mul_flags         = '0;
        mul_flags[FLAG_N] = acc_sum[WIDTH-1];
        mul_flags[FLAG_Z] = (acc_sum == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            ALUResult <= '0;
            ALUFlag   <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state     <= S_BUSY;
                            out_valid <= 1'b0;
                            a_sh      <= SrcA;
                            b_sh      <= SrcB;
                            acc       <= '0;
                            count     <= CW'(WIDTH - 1);
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            ALUResult <= res_c;
                            ALUFlag   <= flags_c;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    acc   <= acc_sum;
                    a_sh  <= a_sh << 1;
                    b_sh  <= b_sh >> 1;
                    count <= count - 1'b1;
                    // Always runs the full WIDTH iterations for a fixed latency.
                    if (count == '0) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        ALUResult <= acc_sum;
                        ALUFlag   <= mul_flags;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
